imem_fetch_ctrl: RTL and testbench

//  Sequences the synchronous instruction memory: owns the PC, issues word reads, presents each

---
 rtl/imem_fetch_pkg.sv | 25 ++
 rtl/imem_fetch_perf.sv | 40 ++++
 rtl/imem_fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction-memory fetch controller.
//   IMEM_ADDR_W   : default word-address width of the instruction memory
//   IMEM_RESET_PC : default byte PC loaded at reset
//   PC_STEP       : byte increment between sequential instructions
//   fetch_state_t : fetch sequencer states
//   align_pc      : forces a byte address onto a word boundary
package imem_fetch_pkg;

  localparam int unsigned IMEM_ADDR_W   = 8;
  localparam logic [31:0] IMEM_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    HOLD = 3'd3,
    LOAD = 3'd4
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/imem_fetch_perf.sv
// Fetch performance counters.
//   clock, reset_n : clock and synchronous active-low reset
//   fetch_inc      : one decode handshake completed this cycle
//   stall_inc      : decode held off a valid instruction this cycle
//   perf_fetched   : running count of handshakes (wraps at 2^32)
//   perf_stall     : running count of stall cycles (wraps at 2^32)
module imem_fetch_perf (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  // Next-count logic; additions wrap naturally at 32 bits.
  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (fetch_inc) fetched_d = 32'(fetched_q + 32'd1);
    if (stall_inc) stall_d   = 32'(stall_q + 32'd1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetched_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads the synchronous instruction
// memory one word at a time, and hands each word to decode over valid/ready.
// Also lends the memory to a program loader for writes.
//   clock, reset_n          : clock and synchronous active-low reset
//   imem_addr/rd/wr/wdata   : memory request side (combinational decode of state)
//   imem_rdata              : read data, valid the cycle after imem_rd
//   ld_req/addr/data, ld_gnt: program-loader write port
//   redirect, redirect_pc   : branch/jump redirect pulse and target
//   dec_valid/ready/instr/pc: registered decode handshake
// Optional build macro IMEM_PERF_CNT_EN adds perf_fetched / perf_stall outputs.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter logic [31:0] RESET_PC = IMEM_RESET_PC
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  output logic              imem_wr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_gnt,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_instr,
  output logic [31:0]       dec_pc
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         dec_valid_q, dec_valid_d;
  logic [31:0]  dec_instr_q, dec_instr_d;
  logic [31:0]  dec_pc_q, dec_pc_d;

  // Next-state, datapath and memory-strobe decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_valid_d = dec_valid_q;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    imem_rd     = 1'b0;
    imem_wr     = 1'b0;
    ld_gnt      = 1'b0;
    imem_addr   = pc_q[ADDR_W+1:2];

    case (state_q)
      IDLE: begin
        state_d = ld_req ? LOAD : REQ;
      end
      REQ: begin
        // Loader is checked before the read is issued, so a grant never
        // leaves a read in flight; a redirect simply re-arms REQ.
        if (redirect) begin
          pc_d = align_pc(redirect_pc);
        end else if (ld_req) begin
          state_d = LOAD;
        end else begin
          imem_rd = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (redirect) begin
          pc_d    = align_pc(redirect_pc);
          state_d = REQ;
        end else begin
          dec_instr_d = imem_rdata;
          dec_pc_d    = pc_q;
          dec_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        // Redirect beats a same-cycle handshake: the held word is discarded.
        if (redirect) begin
          pc_d        = align_pc(redirect_pc);
          dec_valid_d = 1'b0;
          state_d     = REQ;
        end else if (dec_ready) begin
          pc_d        = 32'(pc_q + PC_STEP);
          dec_valid_d = 1'b0;
          state_d     = REQ;
        end
      end
      LOAD: begin
        // Redirect only retargets the PC; the loader keeps ownership.
        if (redirect) pc_d = align_pc(redirect_pc);
        if (ld_req) begin
          ld_gnt    = 1'b1;
          imem_wr   = 1'b1;
          imem_addr = ld_addr;
        end else begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      dec_valid_q <= 1'b0;
      dec_instr_q <= 32'd0;
      dec_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
    end
  end

  assign imem_wdata = ld_data;
  assign dec_valid  = dec_valid_q;
  assign dec_instr  = dec_instr_q;
  assign dec_pc     = dec_pc_q;

`ifdef IMEM_PERF_CNT_EN
  logic fetch_inc_c;
  logic stall_inc_c;

  // A handshake overridden by a redirect is not counted as a fetch.
  assign fetch_inc_c = (state_q == HOLD) && dec_ready && !redirect;
  assign stall_inc_c = (state_q == HOLD) && !dec_ready;

  imem_fetch_perf u_perf (
    .clock        (clock),
    .reset_n      (reset_n),
    .fetch_inc    (fetch_inc_c),
    .stall_inc    (stall_inc_c),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 256-word memory.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_imem_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic        imem_wr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata = 32'd0;
  logic        ld_req;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_gnt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
`ifdef IMEM_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int overlap = 0;
  int n;

  logic [31:0] mem [256];
  logic        mem_ready = 1'b0;

  imem_fetch_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_wr     (imem_wr),
    .imem_wdata  (imem_wdata),
    .imem_rdata  (imem_rdata),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_gnt      (ld_gnt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc)
`ifdef IMEM_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous memory: word i initially holds 32'hC0DE_0000 + i.
  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
      mem_ready <= 1'b1;
    end else begin
      if (imem_wr) mem[imem_addr] <= imem_wdata;
      if (imem_rd) imem_rdata <= mem[imem_addr];
    end
  end

  always @(negedge clock) if (imem_rd && imem_wr) overlap++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Advance until dec_valid is seen; returns the number of cycles taken.
  task automatic wait_valid(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!dec_valid && cyc < max_cyc);
    if (!dec_valid) chk("valid_timeout", 32'(dec_valid), 32'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    ld_req      = 1'b0;
    ld_addr     = 8'd0;
    ld_data     = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    dec_ready   = 1'b1;
    step();
    step();
    // Reset state
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_instr", dec_instr, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_rd", 32'(imem_rd), 32'd0);
    chk("rst_gnt", 32'(ld_gnt), 32'd0);
    reset_n = 1'b1;

    // 1: sequential fetch, one word per 3 cycles
    step();
    chk("t1_rd", 32'(imem_rd), 32'd1);
    chk("t1_addr", 32'(imem_addr), 32'd0);
    wait_valid(10, n);
    chk("t1_lat0", 32'(n), 32'd2);
    chk("t1_instrA", dec_instr, 32'hC0DE_0000);
    chk("t1_pcA", dec_pc, 32'h0);
    wait_valid(10, n);
    chk("t1_lat1", 32'(n), 32'd3);
    chk("t1_instrB", dec_instr, 32'hC0DE_0001);
    chk("t1_pcB", dec_pc, 32'h4);
    wait_valid(10, n);
    chk("t1_lat2", 32'(n), 32'd3);
    chk("t1_instrC", dec_instr, 32'hC0DE_0002);
    chk("t1_pcC", dec_pc, 32'h8);

    // 2: decode stalls for 5 cycles
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_valid", 32'(dec_valid), 32'd1);
      chk("t2_instr", dec_instr, 32'hC0DE_0002);
      chk("t2_pc", dec_pc, 32'h8);
    end
    dec_ready = 1'b1;
    step();
    chk("t2_drop", 32'(dec_valid), 32'd0);
    chk("t2_addr", 32'(imem_addr), 32'd3);

    // 3: redirect while the read response is due
    step();
    chk("t3_resp", 32'(dec_valid), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h13;
    step();
    redirect = 1'b0;
    chk("t3_valid", 32'(dec_valid), 32'd0);
    chk("t3_addr", 32'(imem_addr), 32'd4);
    wait_valid(10, n);
    chk("t3_instr", dec_instr, 32'hC0DE_0004);
    chk("t3_pc", dec_pc, 32'h10);

    // Redirect beats a same-cycle handshake
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("t3b_valid", 32'(dec_valid), 32'd0);
    chk("t3b_addr", 32'(imem_addr), 32'h10);
    wait_valid(10, n);
    chk("t3b_instr", dec_instr, 32'hC0DE_0010);
    chk("t3b_pc", dec_pc, 32'h40);

    // 5: PC wrap of the word address
    redirect    = 1'b1;
    redirect_pc = 32'h3FC;
    step();
    redirect = 1'b0;
    chk("t5_addr_ff", 32'(imem_addr), 32'hFF);
    wait_valid(10, n);
    chk("t5_instr", dec_instr, 32'hC0DE_00FF);
    chk("t5_pc", dec_pc, 32'h3FC);
    step();
    chk("t5_addr_wrap", 32'(imem_addr), 32'h00);
    chk("t5_rd", 32'(imem_rd), 32'd1);
    wait_valid(10, n);
    chk("t5_instr2", dec_instr, 32'hC0DE_0000);
    chk("t5_pc2", dec_pc, 32'h400);

    // 4: reset mid-operation, then loader claims memory from IDLE
    reset_n = 1'b0;
    ld_req  = 1'b1;
    ld_addr = 8'd0;
    ld_data = 32'hB00C_0000;
    step();
    chk("t4_rst_valid", 32'(dec_valid), 32'd0);
    chk("t4_rst_pc", dec_pc, 32'h0);
    chk("t4_idle_gnt", 32'(ld_gnt), 32'd0);
    chk("t4_idle_rd", 32'(imem_rd), 32'd0);
`ifdef IMEM_PERF_CNT_EN
    chk("t6_rst_fetched", perf_fetched, 32'd0);
    chk("t6_rst_stall", perf_stall, 32'd0);
`endif
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      ld_addr = 8'(i);
      ld_data = 32'hB00C_0000 + 32'(i);
      #1;
      chk("t4_gnt", 32'(ld_gnt), 32'd1);
      chk("t4_wr", 32'(imem_wr), 32'd1);
      chk("t4_rd", 32'(imem_rd), 32'd0);
      chk("t4_addr", 32'(imem_addr), 32'(i));
    end
    step();
    ld_req = 1'b0;
    #1;
    chk("t4_gnt_off", 32'(ld_gnt), 32'd0);
    step();
    chk("t4_fetch_rd", 32'(imem_rd), 32'd1);
    chk("t4_fetch_addr", 32'(imem_addr), 32'd0);
    wait_valid(10, n);
    chk("t4_instr", dec_instr, 32'hB00C_0000);
    chk("t4_pc", dec_pc, 32'h0);

    // 6: stall 4 cycles, then three handshakes
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_hold", dec_instr, 32'hB00C_0000);
    end
    dec_ready = 1'b1;
    wait_valid(10, n);
    chk("t6_instr1", dec_instr, 32'hB00C_0001);
    chk("t6_pc1", dec_pc, 32'h4);
    wait_valid(10, n);
    chk("t6_instr2", dec_instr, 32'hB00C_0002);
    step();
    dec_ready = 1'b0;
`ifdef IMEM_PERF_CNT_EN
    chk("t6_fetched", perf_fetched, 32'd3);
    chk("t6_stall", perf_stall, 32'd4);
    reset_n = 1'b0;
    step();
    chk("t6_clr_fetched", perf_fetched, 32'd0);
    chk("t6_clr_stall", perf_stall, 32'd0);
    reset_n = 1'b1;
`endif
    step();
    chk("rd_wr_exclusive", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
